minirv_multicycle_core: RTL and testbench

//  Parametrised multi-cycle RV32I-subset integer core; successor to the single-cycle mini core.

---
 rtl/minirv_multicycle_core.sv | 246 ++++++++++++++++++++++++
 tb/tb_minirv_multicycle_core.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/minirv_multicycle_core.sv
// minirv_multicycle_core: multi-cycle RV32I-subset core (FETCH -> EXEC -> WB).
// Build option: define MINIRV_MUL_EN to add MUL, which runs as a shift-add
// multiplier in a dedicated MUL state. When it is undefined, that encoding halts as illegal.
module minirv_multicycle_core #(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] pc,
    input  logic [4:0]      probe_sel,
    output logic [XLEN-1:0] probe_data,
    output logic            retire,
    output logic            illegal
);
    localparam int SW = $clog2(XLEN);
    localparam int RW = $clog2(NREGS);

`ifdef MINIRV_MUL_EN
    typedef enum logic [2:0] {S_FETCH, S_EXEC, S_WB, S_HALT, S_MUL} state_t;
`else
    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_WB, S_HALT} state_t;
`endif

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [31:0]     ir_q, ir_d;
    logic [XLEN-1:0] res_q, res_d;
    logic [XLEN-1:0] npc_q, npc_d;
    logic            wen_q, wen_d;
`ifdef MINIRV_MUL_EN
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [SW-1:0]   cnt_q, cnt_d;
`endif

    // Instruction fields and sign-extended immediates of the latched word
    logic [6:0]         opcode, funct7;
    logic [2:0]         funct3;
    logic [4:0]         rd_f, rs1_f, rs2_f;
    logic signed [11:0] imm12;
    logic signed [12:0] immb13;
    logic signed [20:0] immj21;
    logic signed [31:0] immu32;
    logic [XLEN-1:0]    imm_i, imm_b, imm_j, imm_u, rs1v, rs2v;

    assign opcode = ir_q[6:0];
    assign rd_f   = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1_f  = ir_q[19:15];
    assign rs2_f  = ir_q[24:20];
    assign funct7 = ir_q[31:25];
    assign imm12  = ir_q[31:20];
    assign immb13 = {ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign immj21 = {ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
    assign immu32 = {ir_q[31:12], 12'b0};
    assign imm_i  = XLEN'(imm12);
    assign imm_b  = XLEN'(immb13);
    assign imm_j  = XLEN'(immj21);
    assign imm_u  = XLEN'(immu32);
    assign rs1v   = regs_q[rs1_f[RW-1:0]];
    assign rs2v   = regs_q[rs2_f[RW-1:0]];

    // Decode/execute: result, next pc, write enable and legality of the latched instruction
    logic            x_illegal, x_wen, x_mul, use_rs1, use_rs2, use_rd;
    logic [XLEN-1:0] x_res, x_npc;
    always_comb begin
        x_illegal = 1'b0;
        x_wen     = 1'b0;
        x_mul     = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        use_rd    = 1'b0;
        x_res     = '0;
        x_npc     = pc_q + XLEN'(4);
        case (opcode)
            7'b0110011: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1; x_wen = 1'b1;
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000:  x_res = rs1v + rs2v;
                        3'b001:  x_res = rs1v << rs2v[SW-1:0];
                        3'b010:  x_res = XLEN'($signed(rs1v) < $signed(rs2v));
                        3'b100:  x_res = rs1v ^ rs2v;
                        3'b101:  x_res = rs1v >> rs2v[SW-1:0];
                        3'b110:  x_res = rs1v | rs2v;
                        3'b111:  x_res = rs1v & rs2v;
                        default: x_illegal = 1'b1;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    x_res = rs1v - rs2v;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    x_res = $signed(rs1v) >>> rs2v[SW-1:0];
`ifdef MINIRV_MUL_EN
                end else if (funct7 == 7'b0000001 && funct3 == 3'b000) begin
                    x_mul = 1'b1;
`endif
                end else begin
                    x_illegal = 1'b1;
                end
            end
            7'b0010011: begin
                use_rs1 = 1'b1; use_rd = 1'b1; x_wen = 1'b1;
                case (funct3)
                    3'b000: x_res = rs1v + imm_i;
                    3'b010: x_res = XLEN'($signed(rs1v) < $signed(imm_i));
                    3'b100: x_res = rs1v ^ imm_i;
                    3'b001: begin
                        x_res = rs1v << ir_q[20 +: SW];
                        x_illegal = (funct7[6:1] != 6'b000000) || (XLEN == 32 && funct7[0]);
                    end
                    3'b101: begin
                        x_res = funct7[5] ? XLEN'($signed(rs1v) >>> ir_q[20 +: SW])
                                          : rs1v >> ir_q[20 +: SW];
                        x_illegal = ({funct7[6], funct7[4:1]} != 5'b00000) || (XLEN == 32 && funct7[0]);
                    end
                    default: x_illegal = 1'b1;
                endcase
            end
            7'b0110111: begin
                use_rd = 1'b1; x_wen = 1'b1;
                x_res  = imm_u;
            end
            7'b1100011: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                case (funct3)
                    3'b000:  if (rs1v == rs2v) x_npc = pc_q + imm_b;
                    3'b001:  if (rs1v != rs2v) x_npc = pc_q + imm_b;
                    3'b100:  if ($signed(rs1v) <  $signed(rs2v)) x_npc = pc_q + imm_b;
                    3'b101:  if ($signed(rs1v) >= $signed(rs2v)) x_npc = pc_q + imm_b;
                    default: x_illegal = 1'b1;
                endcase
            end
            7'b1101111: begin
                use_rd = 1'b1; x_wen = 1'b1;
                x_res  = pc_q + XLEN'(4);
                x_npc  = pc_q + imm_j;
            end
            7'b1100111: begin
                use_rs1 = 1'b1; use_rd = 1'b1; x_wen = 1'b1;
                x_res   = pc_q + XLEN'(4);
                x_npc   = (rs1v + imm_i) & ~XLEN'(1);
                x_illegal = (funct3 != 3'b000);
            end
            default: x_illegal = 1'b1;
        endcase
        if ((use_rd && int'(rd_f) >= NREGS) || (use_rs1 && int'(rs1_f) >= NREGS) ||
            (use_rs2 && int'(rs2_f) >= NREGS))
            x_illegal = 1'b1;
    end

    // Sequencer: next state, pc, register file and execute latches
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        regs_d  = regs_q;
        ir_d    = ir_q;
        res_d   = res_q;
        npc_d   = npc_q;
        wen_d   = wen_q;
`ifdef MINIRV_MUL_EN
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
`endif
        case (state_q)
            S_FETCH: begin
                if (instr_valid) begin
                    ir_d    = instr;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                res_d   = x_res;
                npc_d   = x_npc;
                wen_d   = x_wen;
                state_d = x_illegal ? S_HALT : S_WB;
`ifdef MINIRV_MUL_EN
                if (x_mul && !x_illegal) begin
                    mcand_d  = rs1v;
                    mplier_d = rs2v;
                    res_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_MUL;
                end
            end
            S_MUL: begin
                if (mplier_q[0]) res_d = res_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + SW'(1);
                if (cnt_q == SW'(XLEN - 1)) state_d = S_WB;
`endif
            end
            S_WB: begin
                if (wen_q && rd_f != 5'd0) regs_d[rd_f[RW-1:0]] = res_q;
                pc_d    = npc_q;
                state_d = S_FETCH;
            end
            default: state_d = S_HALT;
        endcase
    end

    // Architectural state; reset aborts any instruction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            regs_q  <= regs_d;
        end
    end

    // Execute latches; only meaningful while the sequencer is past FETCH
    always_ff @(posedge clk) begin
        ir_q  <= ir_d;
        res_q <= res_d;
        npc_q <= npc_d;
        wen_q <= wen_d;
`ifdef MINIRV_MUL_EN
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
        cnt_q    <= cnt_d;
`endif
    end

    // Debug probe: out-of-range indices read as zero
    always_comb begin
        probe_data = '0;
        if (int'(probe_sel) < NREGS) probe_data = regs_q[probe_sel[RW-1:0]];
    end

    assign instr_ready = (state_q == S_FETCH);
    assign retire      = (state_q == S_WB);
    assign illegal     = (state_q == S_HALT);
    assign pc          = pc_q;
endmodule

// File: tb/tb_minirv_multicycle_core.sv
// Directed bench for minirv_multicycle_core: an instruction table plus hand-written
// sequences for branches, jumps, stalls, reset aborts, halts, MUL and a 16-register core.
module tb_minirv_multicycle_core;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = '0;
    logic [31:0] pc;
    logic [4:0]  probe_sel = '0;
    logic [31:0] probe_data;
    logic        retire, illegal;

    logic        v2 = 1'b0;
    logic        rdy2, ret2, ill2;
    logic [31:0] instr2 = '0;
    logic [31:0] pc2, pdata2;
    logic [4:0]  psel2 = '0;

    int n_chk = 0;
    int n_fail = 0;
    int ret_cnt = 0;

    minirv_multicycle_core dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .pc(pc), .probe_sel(probe_sel), .probe_data(probe_data),
        .retire(retire), .illegal(illegal)
    );

    minirv_multicycle_core #(.NREGS(16)) dut16 (
        .clk(clk), .reset(reset), .instr_valid(v2), .instr_ready(rdy2),
        .instr(instr2), .pc(pc2), .probe_sel(psel2), .probe_data(pdata2),
        .retire(ret2), .illegal(ill2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (retire) ret_cnt <= ret_cnt + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [31:0] val;
        logic [31:0] pc;
    } vec_t;

    localparam int NV = 23;
    vec_t tbl [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Offer one instruction and follow it to retirement or halt; cyc counts
    // negedges from offer until the core is back in FETCH (or has halted).
    task automatic run_instr(input logic [31:0] w, output int cyc, output bit done);
        cyc = 0;
        done = 1'b0;
        instr = w;
        instr_valid = 1'b1;
        while (!instr_ready && cyc < 50) begin @(negedge clk); cyc++; end
        if (!instr_ready) begin
            check("accept_timeout", 32'(instr_ready), 32'd1);
            instr_valid = 1'b0;
            return;
        end
        @(negedge clk); cyc++;
        instr_valid = 1'b0;
        while (!retire && !illegal && cyc < 100) begin @(negedge clk); cyc++; end
        if (retire) begin
            @(negedge clk); cyc++;
            done = 1'b1;
        end else if (!illegal) begin
            check("retire_timeout", 32'(retire), 32'd1);
        end
    endtask

    task automatic step(input logic [31:0] w, input string name);
        int  cyc;
        bit  done;
        run_instr(w, cyc, done);
        check({name, "_retired"}, 32'(done), 32'd1);
    endtask

    task automatic probe(input logic [4:0] r, input logic [31:0] exp, input string name);
        probe_sel = r;
        #1;
        check(name, probe_data, exp);
    endtask

    initial begin
        int  cyc, r0;
        bit  done;
        logic [31:0] pc_save;

        tbl[0]  = '{32'h00500513, 5'd10, 32'd5,        32'd4};
        tbl[1]  = '{32'h00700093, 5'd1,  32'd7,        32'd8};
        tbl[2]  = '{32'h00300113, 5'd2,  32'd3,        32'd12};
        tbl[3]  = '{32'h402081B3, 5'd3,  32'd4,        32'd16};
        tbl[4]  = '{32'h80000237, 5'd4,  32'h80000000, 32'd20};
        tbl[5]  = '{32'h40425293, 5'd5,  32'hF8000000, 32'd24};
        tbl[6]  = '{32'h00400393, 5'd7,  32'd4,        32'd28};
        tbl[7]  = '{32'h40725333, 5'd6,  32'hF8000000, 32'd32};
        tbl[8]  = '{32'h00725433, 5'd8,  32'h08000000, 32'd36};
        tbl[9]  = '{32'hFFF00493, 5'd9,  32'hFFFFFFFF, 32'd40};
        tbl[10] = '{32'h00100613, 5'd12, 32'd1,        32'd44};
        tbl[11] = '{32'h00C4A5B3, 5'd11, 32'd1,        32'd48};
        tbl[12] = '{32'h009626B3, 5'd13, 32'd0,        32'd52};
        tbl[13] = '{32'h002267B3, 5'd15, 32'h80000003, 32'd56};
        tbl[14] = '{32'h0020C733, 5'd14, 32'd4,        32'd60};
        tbl[15] = '{32'h0020F833, 5'd16, 32'd3,        32'd64};
        tbl[16] = '{32'h007618B3, 5'd17, 32'd16,       32'd68};
        tbl[17] = '{32'h00208933, 5'd18, 32'd10,       32'd72};
        tbl[18] = '{32'hFFF0C993, 5'd19, 32'hFFFFFFF8, 32'd76};
        tbl[19] = '{32'h0004AA13, 5'd20, 32'd1,        32'd80};
        tbl[20] = '{32'h01F61A93, 5'd21, 32'h80000000, 32'd84};
        tbl[21] = '{32'h01F25B13, 5'd22, 32'd1,        32'd88};
        tbl[22] = '{32'h00500013, 5'd0,  32'd0,        32'd92};

        // Reset state
        do_reset();
        #1;
        check("reset_pc", pc, 32'd0);
        check("reset_retire", 32'(retire), 32'd0);
        check("reset_illegal", 32'(illegal), 32'd0);
        check("reset_ready", 32'(instr_ready), 32'd1);
        probe(5'd10, 32'd0, "reset_x10");

        // Table of ALU/immediate instructions, each 3 cycles with one retire
        for (int i = 0; i < NV; i++) begin
            r0 = ret_cnt;
            run_instr(tbl[i].instr, cyc, done);
            check($sformatf("done[%0d]", i), 32'(done), 32'd1);
            check($sformatf("cycles[%0d]", i), 32'(cyc), 32'd3);
            check($sformatf("retire_once[%0d]", i), 32'(ret_cnt - r0), 32'd1);
            check($sformatf("pc[%0d]", i), pc, tbl[i].pc);
            probe(tbl[i].rd, tbl[i].val, $sformatf("rd[%0d]", i));
        end

        // instr_valid low for 5 cycles: nothing moves
        pc_save = pc;
        r0 = ret_cnt;
        repeat (5) @(negedge clk);
        check("stall_pc", pc, pc_save);
        check("stall_retire", 32'(ret_cnt - r0), 32'd0);
        check("stall_ready", 32'(instr_ready), 32'd1);

        // JAL / JALR
        do_reset();
        step(32'h00000013, "nop_a");
        step(32'h00000013, "nop_b");
        step(32'h010000EF, "jal");
        probe(5'd1, 32'd12, "jal_link");
        check("jal_pc", pc, 32'd24);
        step(32'h00108067, "jalr_x0");
        check("jalr_pc", pc, 32'd12);
        probe(5'd0, 32'd0, "jalr_x0_zero");
        step(32'h008080E7, "jalr_x1");
        check("jalr_same_pc", pc, 32'd20);
        probe(5'd1, 32'd16, "jalr_same_link");

        // Reset while in EXEC aborts the instruction
        r0 = ret_cnt;
        instr = 32'h00900293;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_pc", pc, 32'd0);
        check("abort_retire", 32'(ret_cnt - r0), 32'd0);
        probe(5'd5, 32'd0, "abort_x5");
        @(negedge clk);
        check("abort_ready", 32'(instr_ready), 32'd1);

        // Branches from pc=8
        step(32'h00700093, "br_x1");
        step(32'h00700113, "br_x2");
        step(32'hFE208CE3, "beq");
        check("beq_pc", pc, 32'd0);
        step(32'h00000013, "nop_c");
        step(32'h00000013, "nop_d");
        step(32'hFE209CE3, "bne");
        check("bne_pc", pc, 32'd12);
        step(32'h0020D463, "bge");
        check("bge_pc", pc, 32'd20);
        step(32'h0020C463, "blt");
        check("blt_pc", pc, 32'd24);

        // MUL 6*7
        do_reset();
        step(32'h00600093, "mul_x1");
        step(32'h00700113, "mul_x2");
        run_instr(32'h022081B3, cyc, done);
`ifdef MINIRV_MUL_EN
        check("mul_done", 32'(done), 32'd1);
        check("mul_cycles", 32'(cyc), 32'd35);
        probe(5'd3, 32'd42, "mul_x3");
        check("mul_pc", pc, 32'd12);
`else
        check("mul_illegal", 32'(illegal), 32'd1);
        check("mul_ready", 32'(instr_ready), 32'd0);
        probe(5'd3, 32'd0, "mul_x3");
        check("mul_pc", pc, 32'd8);
`endif

        // All-zero word halts until reset
        do_reset();
        r0 = ret_cnt;
        run_instr(32'h00000000, cyc, done);
        check("zero_illegal", 32'(illegal), 32'd1);
        check("zero_ready", 32'(instr_ready), 32'd0);
        instr_valid = 1'b1;
        repeat (3) @(negedge clk);
        instr_valid = 1'b0;
        check("halt_pc", pc, 32'd0);
        check("halt_held", 32'(illegal), 32'd1);
        check("halt_retire", 32'(ret_cnt - r0), 32'd0);
        do_reset();
        #1;
        check("halt_cleared", 32'(illegal), 32'd0);

        // 16-register core: x15 legal, x20 illegal
        @(negedge clk);
        instr2 = 32'h00300793;
        v2 = 1'b1;
        @(negedge clk);
        v2 = 1'b0;
        repeat (2) @(negedge clk);
        psel2 = 5'd15;
        #1;
        check("e_x15", pdata2, 32'd3);
        check("e_pc", pc2, 32'd4);
        instr2 = 32'h00100A13;
        v2 = 1'b1;
        @(negedge clk);
        v2 = 1'b0;
        @(negedge clk);
        check("e_x20_illegal", 32'(ill2), 32'd1);
        check("e_x20_ready", 32'(rdy2), 32'd0);
        check("e_x20_pc", pc2, 32'd4);
        psel2 = 5'd20;
        #1;
        check("e_probe_oob", pdata2, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
